// File: rtl/aes_pkg.sv
// Shared definitions for the streaming AES key schedule.
// Contents: key-mode encodings, FSM state encodings, Nk/Nr/Nw lookups
// for each key mode, and the GF(2^8) xtime helper used to step rcon.
package aes_pkg;

    // Key-mode encodings as presented on key_mode. The reserved code is
    // handled as AES-128.
    localparam logic [1:0] MODE_128  = 2'd0;
    localparam logic [1:0] MODE_192  = 2'd1;
    localparam logic [1:0] MODE_256  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // Controller states.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_EXPAND = 3'd2;
    localparam logic [2:0] ST_READY  = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 4'd6;
            MODE_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    // Total schedule length in words, 4*(Nr+1).
    function automatic logic [5:0] nw_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 6'd52;
            MODE_256: return 6'd60;
            default:  return 6'd44;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
// Ports:
//   byte_i  8-bit input byte
//   byte_o  8-bit substituted byte
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Table stored with entry 0x00 in the top byte, so entry a sits at
    // bit offset 8*(255-a), which is simply {~a, 3'b000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX[{~byte_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule_stream.sv
// Byte-serial AES-128/192/256 key loader, word-per-cycle key expander and
// round-key streamer.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   key_mode                      key size, sampled with the first key byte
//   key_in/_valid/_ready          key bytes, most significant first
//   keys_ready                    full schedule valid
//   num_rounds                    Nr of the latched mode (0 before first load)
//   rk_req_valid/_ready, rk_round round-key request
//   rk_err                        one-cycle pulse after an out-of-range request
//   rk_out/_valid/_ready/_last    round-key beats, most significant first
module aes_key_schedule_stream
    import aes_pkg::*;
#(
    parameter int OUT_W     = 8,
    parameter int MAX_WORDS = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       key_mode,
    input  logic             key_in_valid,
    output logic             key_in_ready,
    input  logic [7:0]       key_in,
    output logic             keys_ready,
    output logic [3:0]       num_rounds,
    input  logic             rk_req_valid,
    output logic             rk_req_ready,
    input  logic [3:0]       rk_round,
    output logic             rk_err,
    output logic [OUT_W-1:0] rk_out,
    output logic             rk_out_valid,
    input  logic             rk_out_ready,
    output logic             rk_out_last
);

    localparam int BEATS  = 128 / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        nr_q, nr_d;
    logic [4:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       acc_q, acc_d;     // bytes of the word being packed
    logic [5:0]        idx_q, idx_d;     // word index i during expansion
    logic [2:0]        phase_q, phase_d; // i mod Nk, kept as a wrapping counter
    logic [7:0]        rcon_q, rcon_d;
    logic [31:0]       prev_q, prev_d;   // last word written, i.e. w[i-1]
    logic [3:0]        round_q, round_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              err_q, err_d;

    logic [31:0] mem_q [MAX_WORDS];
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;

    logic [3:0]   nk;
    logic [5:0]   nw;
    logic [5:0]   key_bytes;
    logic         key_fire;
    logic [31:0]  w_back;
    logic [31:0]  sub_in, sub_out, temp, w_new;
    logic [5:0]   rd_base;
    logic [127:0] key128;
    logic [6:0]   sel_lsb;

    assign nk        = nk_of(mode_q);
    assign nw        = nw_of(mode_q);
    assign key_bytes = {nk, 2'b00};

    assign key_in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                          (state_q == ST_READY);
    assign key_fire     = key_in_valid && key_in_ready;
    assign keys_ready   = (state_q == ST_READY) || (state_q == ST_STREAM);
    // A key byte in READY starts a reload and pre-empts any request.
    assign rk_req_ready = (state_q == ST_READY) && !key_in_valid;
    assign rk_err       = err_q;
    assign num_rounds   = nr_q;

    // Expansion datapath: RotWord only on the Nk boundary; one shared
    // SubWord serves both the boundary and the AES-256 mid-key step.
    assign w_back = mem_q[idx_q - {2'b00, nk}];
    assign sub_in = (phase_q == 3'd0) ? {prev_q[23:0], prev_q[31:24]} : prev_q;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .byte_i(sub_in[8*g +: 8]),
            .byte_o(sub_out[8*g +: 8])
        );
    end

    always_comb begin
        if (phase_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (nk == 4'd8 && phase_q == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = prev_q;
        end
    end

    assign w_new = w_back ^ temp;

    // Round-key read path, gated so the bus is quiet outside STREAM.
    assign rd_base = {round_q, 2'b00};
    assign key128  = {mem_q[rd_base], mem_q[rd_base + 6'd1],
                      mem_q[rd_base + 6'd2], mem_q[rd_base + 6'd3]};
    assign sel_lsb = 7'(OUT_W * (BEATS - 1)) - 7'(beat_q) * 7'(OUT_W);

    assign rk_out_valid = (state_q == ST_STREAM);
    assign rk_out_last  = (state_q == ST_STREAM) && (beat_q == BEAT_LAST);
    assign rk_out       = (state_q == ST_STREAM) ? key128[sel_lsb +: OUT_W] : '0;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        nr_d       = nr_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        rcon_d     = rcon_q;
        prev_d     = prev_q;
        round_d    = round_q;
        beat_d     = beat_q;
        err_d      = 1'b0;
        we         = 1'b0;
        waddr      = idx_q;
        wdata      = w_new;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (key_fire) begin
                    // First byte of a (re)load: latch the key size now.
                    mode_d     = (key_mode == MODE_RSVD) ? MODE_128 : key_mode;
                    nr_d       = nr_of(key_mode);
                    acc_d      = {acc_q[15:0], key_in};
                    byte_cnt_d = 5'd1;
                    state_d    = ST_LOAD;
                end else if (state_q == ST_READY && rk_req_valid) begin
                    if (rk_round <= nr_q) begin
                        round_d = rk_round;
                        beat_d  = '0;
                        state_d = ST_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (key_in_valid) begin
                    acc_d      = {acc_q[15:0], key_in};
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if (byte_cnt_q[1:0] == 2'd3) begin
                        we     = 1'b1;
                        waddr  = {3'b000, byte_cnt_q[4:2]};
                        wdata  = {acc_q, key_in};
                        prev_d = {acc_q, key_in};
                    end
                    if ({1'b0, byte_cnt_q} == key_bytes - 6'd1) begin
                        idx_d   = {2'b00, nk};
                        phase_d = 3'd0;
                        rcon_d  = 8'h01;
                        state_d = ST_EXPAND;
                    end
                end
            end

            ST_EXPAND: begin
                we      = 1'b1;
                prev_d  = w_new;
                idx_d   = idx_q + 6'd1;
                phase_d = ({1'b0, phase_q} == nk - 4'd1) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (idx_q == nw - 6'd1) begin
                    state_d = ST_READY;
                end
            end

            ST_STREAM: begin
                if (rk_out_ready) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_READY;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_128;
            nr_q       <= 4'd0;
            byte_cnt_q <= 5'd0;
            acc_q      <= 24'h0;
            idx_q      <= 6'd0;
            phase_q    <= 3'd0;
            rcon_q     <= 8'h01;
            prev_q     <= 32'h0;
            round_q    <= 4'd0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            nr_q       <= nr_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            rcon_q     <= rcon_d;
            prev_q     <= prev_d;
            round_q    <= round_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the word store has no reset; it is only read once a full load
    // and expansion have rewritten every word in use, and leaving it out of
    // reset lets it map onto plain RAM. Writes are blocked while in reset
    // because the write enable depends on state_q.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_stream.sv
// Self-checking bench for aes_key_schedule_stream (OUT_W = 8).
// The reference key expansion is computed from a GF(2^8)-derived S-box.
module tb_aes_key_schedule_stream;

    localparam int OUT_W = 8;
    localparam int BEATS = 128 / OUT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       key_mode;
    logic             key_in_valid;
    logic             key_in_ready;
    logic [7:0]       key_in;
    logic             keys_ready;
    logic [3:0]       num_rounds;
    logic             rk_req_valid;
    logic             rk_req_ready;
    logic [3:0]       rk_round;
    logic             rk_err;
    logic [OUT_W-1:0] rk_out;
    logic             rk_out_valid;
    logic             rk_out_ready;
    logic             rk_out_last;

    aes_key_schedule_stream #(.OUT_W(OUT_W), .MAX_WORDS(60)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_mode     (key_mode),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .key_in       (key_in),
        .keys_ready   (keys_ready),
        .num_rounds   (num_rounds),
        .rk_req_valid (rk_req_valid),
        .rk_req_ready (rk_req_ready),
        .rk_round     (rk_round),
        .rk_err       (rk_err),
        .rk_out       (rk_out),
        .rk_out_valid (rk_out_valid),
        .rk_out_ready (rk_out_ready),
        .rk_out_last  (rk_out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_ref [256];
    logic [7:0]  key_bytes [32];
    logic [31:0] w_ref [60];
    int          nr_ref;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                          rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] mode);
        int nk;
        int nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = (mode == 2'd1) ? 6 : (mode == 2'd2) ? 8 : 4;
        nr_ref = nk + 6;
        nw = 4 * (nr_ref + 1);
        for (int i = 0; i < nk; i++)
            w_ref[i] = {key_bytes[4*i], key_bytes[4*i+1], key_bytes[4*i+2], key_bytes[4*i+3]};
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = w_ref[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w_ref[i] = w_ref[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_round(input int r);
        return {w_ref[4*r], w_ref[4*r+1], w_ref[4*r+2], w_ref[4*r+3]};
    endfunction

    task automatic set_key(input logic [255:0] k);
        for (int i = 0; i < 32; i++) key_bytes[i] = k[255-8*i -: 8];
    endtask

    task automatic random_key();
        for (int i = 0; i < 32; i++) key_bytes[i] = 8'($urandom);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check(tag, {key_in_ready, keys_ready, num_rounds, rk_req_ready, rk_err,
                    rk_out_valid, rk_out_last, rk_out},
                   {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] mode);
        bit ok;
        ok = 1'b0;
        key_in_valid = 1'b1;
        key_in       = b;
        key_mode     = mode;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = key_in_ready;
            @(posedge clk); #1;
        end
        key_in_valid = 1'b0;
        if (!ok) check("key_in_ready timeout", 0, 1);
    endtask

    // Mode is driven only with byte 0; later bytes carry junk on key_mode.
    task automatic load_key(input logic [1:0] mode, input int gap_max, input int first);
        int nbytes;
        nbytes = (mode == 2'd1) ? 24 : (mode == 2'd2) ? 32 : 16;
        for (int b = first; b < nbytes; b++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            send_byte(key_bytes[b], (b == 0) ? mode : 2'($urandom));
        end
    endtask

    task automatic wait_keys_ready(output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (keys_ready) ok = 1'b1;
            else cycles++;
            @(posedge clk); #1;
        end
        if (!ok) check("keys_ready timeout", 0, 1);
    endtask

    task automatic request(input logic [3:0] r, input bit throttle, output logic [127:0] got);
        bit ok;
        bit hold;
        int k;
        logic [OUT_W-1:0] held_out;
        logic             held_last;
        ok = 1'b0;
        hold = 1'b0;
        held_out = '0;
        held_last = 1'b0;
        got = '0;
        k = 0;
        rk_req_valid = 1'b1;
        rk_round     = r;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = rk_req_ready;
            @(posedge clk); #1;
        end
        rk_req_valid = 1'b0;
        if (!ok) check("rk_req_ready timeout", 0, 1);
        for (int t = 0; t < 400 && k < BEATS; t++) begin
            rk_out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (hold) begin
                check("stalled rk_out_valid", rk_out_valid, 1);
                check("stalled rk_out", rk_out, held_out);
                check("stalled rk_out_last", rk_out_last, held_last);
            end
            if (rk_out_valid) begin
                if (rk_out_ready) begin
                    check("rk_out_last on beat", rk_out_last, (k == BEATS - 1));
                    got  = {got[127-OUT_W:0], rk_out};
                    k++;
                    hold = 1'b0;
                end else begin
                    hold      = 1'b1;
                    held_out  = rk_out;
                    held_last = rk_out_last;
                end
            end
            @(posedge clk); #1;
        end
        rk_out_ready = 1'b0;
        if (k < BEATS) check("stream beat count", k, BEATS);
        // Back in READY the cycle after the last handshake.
        @(negedge clk);
        check("rk_req_ready after last", {rk_req_ready, rk_out_valid}, 2'b10);
        @(posedge clk); #1;
    endtask

    task automatic bad_request(input logic [3:0] r);
        int errs;
        int vals;
        errs = 0;
        vals = 0;
        rk_req_valid = 1'b1;
        rk_round     = r;
        @(negedge clk);
        check("rk_req_ready for bad round", rk_req_ready, 1);
        @(posedge clk); #1;
        rk_req_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            errs += int'(rk_err);
            vals += int'(rk_out_valid);
            @(posedge clk); #1;
        end
        check("rk_err pulse count", errs, 1);
        check("rk_out_valid after bad request", vals, 0);
        check("keys_ready after bad request", keys_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got;
        int           lat;
        logic [1:0]   mode;
        int           r;

        rst_n        = 1'b1;
        key_mode     = 2'd0;
        key_in_valid = 1'b0;
        key_in       = 8'h00;
        rk_req_valid = 1'b0;
        rk_round     = 4'd0;
        rk_out_ready = 1'b0;
        build_sbox();

        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset outputs");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // AES-128 FIPS-197 key, contiguous bytes.
        set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        model_expand(2'd0);
        load_key(2'd0, 0, 0);
        wait_keys_ready(lat);
        check("aes128 expand cycles after last byte", lat, 40);
        check("aes128 num_rounds", num_rounds, 10);
        request(4'd10, 1'b0, got);
        check("aes128 round10 vector", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        request(4'd0, 1'b1, got);
        check("aes128 round0 model", got, ref_round(0));
        bad_request(4'd11);

        // AES-192.
        set_key({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        model_expand(2'd1);
        load_key(2'd1, 2, 0);
        wait_keys_ready(lat);
        check("aes192 num_rounds", num_rounds, 12);
        request(4'd12, 1'b1, got);
        check("aes192 round12 vector", got, 128'he98ba06f448c773c8ecc720401002202);
        bad_request(4'd13);

        // AES-256.
        set_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        model_expand(2'd2);
        load_key(2'd2, 1, 0);
        wait_keys_ready(lat);
        check("aes256 num_rounds", num_rounds, 14);
        request(4'd14, 1'b1, got);
        check("aes256 round14 vector", got, 128'hfe4890d1e6188d0b046df344706c631e);
        request(4'd0, 1'b0, got);
        check("aes256 round0 vector", got, 128'h603deb1015ca71be2b73aef0857d7781);
        request(4'd7, 1'b1, got);
        check("aes256 round7 model", got, ref_round(7));
        bad_request(4'd15);

        // Reset in the middle of expansion.
        set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        model_expand(2'd0);
        load_key(2'd0, 0, 0);
        repeat (10) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async reset mid-expand");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        load_key(2'd0, 1, 0);
        wait_keys_ready(lat);
        request(4'd10, 1'b1, got);
        check("reload after reset round10", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reload from READY with a competing request in the same cycle.
        random_key();
        model_expand(2'd1);
        rk_req_valid = 1'b1;
        rk_round     = 4'd3;
        key_in_valid = 1'b1;
        key_in       = key_bytes[0];
        key_mode     = 2'd1;
        @(negedge clk);
        check("rk_req_ready with key byte", rk_req_ready, 0);
        check("key_in_ready in READY", key_in_ready, 1);
        @(posedge clk); #1;
        rk_req_valid = 1'b0;
        key_in_valid = 1'b0;
        @(negedge clk);
        check("keys_ready after reload byte", keys_ready, 0);
        check("rk_out_valid after reload byte", rk_out_valid, 0);
        check("num_rounds after reload byte", num_rounds, 12);
        @(posedge clk); #1;
        load_key(2'd1, 2, 1);
        wait_keys_ready(lat);
        request(4'd12, 1'b1, got);
        check("reload aes192 round12 model", got, ref_round(12));
        request(4'd3, 1'b0, got);
        check("reload aes192 round3 model", got, ref_round(3));

        // Random keys and modes, including the reserved mode code.
        for (int it = 0; it < 6; it++) begin
            random_key();
            mode = 2'($urandom_range(0, 3));
            model_expand(mode == 2'd3 ? 2'd0 : mode);
            load_key(mode, 2, 0);
            wait_keys_ready(lat);
            check("random num_rounds", num_rounds, nr_ref);
            for (int j = 0; j < 2; j++) begin
                r = $urandom_range(0, nr_ref);
                request(4'(r), 1'b1, got);
                check($sformatf("random mode%0d round%0d", mode, r), got, ref_round(r));
            end
            request(4'(nr_ref), 1'b0, got);
            check("random last round", got, ref_round(nr_ref));
            bad_request(4'($urandom_range(nr_ref + 1, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_stream.md
Name: aes_key_schedule_stream

Overview:
Parametrised successor to the 128-bit byte-serial key expansion controller. It accepts a cipher key byte-serially and supports AES-128, AES-192 and AES-256, selected at run time. It expands the key one 32-bit word per cycle into an internal round-key store. It then streams any requested round key to the cipher datapath in OUT_W-bit beats under valid/ready backpressure.

Parameters:
OUT_W, 8, round-key output beat width; legal values 8, 32, 128; beats per key = 128/OUT_W.
MAX_WORDS, 60, depth of the word store (4*(14+1)); must not be reduced.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
key_mode  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved (treated as 0); sampled with the first accepted key byte.
key_in_valid  in  1  key byte valid.
key_in_ready  out  1  block accepts a key byte.
key_in  in  8  key byte, most significant byte first.
keys_ready  out  1  full schedule is valid.
num_rounds  out  4  Nr for the latched mode (10/12/14); 0 until the first load starts.
rk_req_valid  in  1  round-key request.
rk_req_ready  out  1  request accepted this cycle.
rk_round  in  4  requested round index, 0..Nr.
rk_err  out  1  one-cycle pulse when an out-of-range round is requested.
rk_out  out  OUT_W  round-key beat, most significant part first.
rk_out_valid  out  1  beat valid.
rk_out_ready  in  1  consumer accepts the beat.
rk_out_last  out  1  final beat of the key.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0 except key_in_ready=1; word store contents don't-care; keys_ready=0.
- Reset asserted mid-load, mid-expansion or mid-stream aborts immediately. No partial beat completes after reset.
- Definitions: Nk = 4/6/8 words; Nr = 10/12/14; total words Nw = 4*(Nr+1) = 44/52/60.
- FSM states: IDLE, LOAD, EXPAND, READY, STREAM.
- IDLE: key_in_ready=1. On the first accepted byte, latch the mode, set num_rounds, write the byte, and go to LOAD.
- LOAD: accepts bytes on key_in_valid & key_in_ready and packs them into w[0..Nk-1]. When byte 4*Nk-1 is accepted, go to EXPAND with i=Nk and rcon=0x01. Gaps in key_in_valid are allowed.
- EXPAND: key_in_ready=0. Each cycle computes w[i] from temp=w[i-1]:
  - if i mod Nk==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon), where xtime = shift left 1, ^0x1b on carry.
  - else if Nk==8 and i mod 8==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - When i==Nw-1, go to READY. Expansion takes Nw-Nk cycles (40/46/52).
- READY: keys_ready=1; key_in_ready=1; rk_req_ready=1.
  - Valid request with rk_round<=Nr: latch round r, beat counter=0, go to STREAM.
  - Request with rk_round>Nr: rk_err pulses for one cycle; stay in READY; no beats.
  - Accepted key byte: keys_ready drops the next cycle and the FSM goes to LOAD. This is a new load; a request in the same cycle loses to the key byte and is not accepted.
- STREAM: rk_req_ready=0; key_in_ready=0; keys_ready stays 1.
  - rk_out holds the slice of {w[4r],w[4r+1],w[4r+2],w[4r+3]} selected by the beat counter.
  - rk_out_valid=1. rk_out, rk_out_valid and rk_out_last are stable while rk_out_ready=0.
  - The counter advances on valid&ready. rk_out_last=1 on beat 128/OUT_W-1; its handshake returns the FSM to READY.
  - Back-to-back: a request can be accepted at the earliest in the cycle after last.
- Store is read-only outside EXPAND/LOAD. The counters i (6 bits) and the beat counter never wrap within legal operation.

Decomposition:
- Shared package aes_pkg: mode encodings, NK/NR/NW lookup constants, the xtime function, state encodings.
- One sub-module, aes_sbox (combinational byte S-box). Instantiate it four times for SubWord.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c; keys_ready rises 16+40 cycles after the first byte. Request round 10, OUT_W=8 -> 16 beats d014f9a8c9ee2589e13f0cc8b6630ca6, last on beat 15.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; num_rounds=12. Round 12 -> e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4. Round 14 -> fe4890d1e6188d0b046df344706c631e; round 0 returns the first 16 key bytes.
- Random rk_out_ready throttling during a stream -> output stable while stalled, byte sequence unchanged; request for round 11 in AES-128 -> rk_err pulse, no rk_out_valid.
- Reset pulsed mid-EXPAND -> all outputs zero asynchronously. A subsequent AES-128 reload reproduces the round-10 vector.
- Reload in READY, with the request and the key byte in the same cycle -> request not accepted, keys_ready low the next cycle, new schedule correct.
